// File: rtl/adder_display_pkg.sv
// Shared types and constants for the adder result display: FSM states,
// conversion length, 7-segment codes and the double-dabble nibble adjust.
package adder_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_e;

  localparam int SHIFT_CYCLES = 5;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [3:0] bcd_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/adder_result_display_seg7.sv
// BCD digit to 7-segment pattern; non-decimal codes produce a blank digit.
module seg7_decode
  import adder_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result, converts it to two BCD digits by
// shift-and-add-3, and scans them onto one 7-segment bus with tens blanking.
module adder_result_display
  import adder_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum_i,
  input  logic       cout_i,
  input  logic       load_i,
  output logic       busy_o,
  output logic [6:0] seg_o,
  output logic [1:0] dig_en_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [2:0]    CNT_LAST   = 3'(SHIFT_CYCLES - 1);

  state_e      state_q;
  logic        busy_q;
  logic [4:0]  bin_q;
  logic [3:0]  tens_q, ones_q;
  logic [2:0]  cnt_q;
  logic [3:0]  disp_tens_q, disp_ones_q;
  logic [PW-1:0] presc_q, presc_d;
  logic        sel_q;

  logic [3:0]  tens_adj, ones_adj;
  logic [12:0] shift_d;

  // Adjust both nibbles first, then shift the whole {tens, ones, bin} chain.
  always_comb begin
    tens_adj = bcd_adj(tens_q);
    ones_adj = bcd_adj(ones_q);
    shift_d  = {tens_adj, ones_adj, bin_q} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      bin_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      cnt_q       <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_i) begin
            bin_q   <= {cout_i, sum_i};
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {tens_q, ones_q, bin_q} <= shift_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          disp_tens_q <= tens_q;
          disp_ones_q <= ones_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Digit scan runs free of the converter; only reset touches it.
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      if (presc_q == PRESC_LAST) begin
        sel_q <= ~sel_q;
      end
    end
  end

  logic [3:0] digit;
  logic [6:0] seg_raw;
  logic       blank;

  assign digit = sel_q ? disp_tens_q : disp_ones_q;
  assign blank = sel_q && (disp_tens_q == 4'd0);

  seg7_decode u_seg7 (
    .bcd_i (digit),
    .seg_o (seg_raw)
  );

  assign seg_o    = blank ? SEG_BLANK : seg_raw;
  assign dig_en_o = blank ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Bench for adder_result_display: directed scenarios plus random loads,
// checked against a latency/arithmetic model of the display.
module tb_adder_result_display;

  localparam int R = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sum_i;
  logic       cout_i;
  logic       load_i;
  logic       busy_o;
  logic [6:0] seg_o;
  logic [1:0] dig_en_o;

  int vectors = 0;
  int errors  = 0;

  adder_result_display #(.REFRESH_DIV(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_i    (sum_i),
    .cout_i   (cout_i),
    .load_i   (load_i),
    .busy_o   (busy_o),
    .seg_o    (seg_o),
    .dig_en_o (dig_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: scan position from edges since reset; display updates 6 edges after capture.
  int edges;
  int disp_m;
  int pend_m;
  int busy_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges     = 0;
      disp_m    = 0;
      busy_left = 0;
    end else begin
      edges++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) disp_m = pend_m;
      end else if (load_i) begin
        pend_m    = {27'd0, cout_i, sum_i};
        busy_left = 6;
      end
    end
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int cur_sel();
    return (edges / R) % 2;
  endfunction

  // {dig_en, seg} the model expects right now.
  function automatic logic [8:0] exp_out();
    int t = disp_m / 10;
    int o = disp_m % 10;
    if (cur_sel() == 1 && t == 0) return 9'b0;
    if (cur_sel() == 1) return {2'b10, seg_of(t)};
    return {2'b01, seg_of(o)};
  endfunction

  task automatic drive_load(input int v);
    sum_i  = v[3:0];
    cout_i = v[4];
    load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] want;
    rst_n = 1'b0;
    sum_i = '0; cout_i = 1'b0; load_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy_o, dig_en_o, seg_o} !== {1'b0, 2'b01, 7'b0111111}) begin
      errors++;
      $display("FAIL reset_vals: got busy=%b en=%b seg=%b, want busy=0 en=01 seg=0111111",
               busy_o, dig_en_o, seg_o);
    end
    @(posedge clk); #1;
    drive_load(23);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_o, dig_en_o, seg_o} !== {1'b0, 2'b01, 7'b0111111}) begin
      errors++;
      $display("FAIL reset_async: got busy=%b en=%b seg=%b, want busy=0 en=01 seg=0111111",
               busy_o, dig_en_o, seg_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2 * R; i++) begin
      @(negedge clk);
      want = (i < R) ? {2'b01, 7'b0111111} : 9'b0;
      vectors++;
      if ({dig_en_o, seg_o} !== want || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan[%0d]: got busy=%b en=%b seg=%b, want busy=0 en=%b seg=%b",
                 i, busy_o, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_load_nine();
    logic [8:0] want;
    @(posedge clk); #1;
    drive_load(9);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if (busy_o !== (k < 6)) begin
        errors++;
        $display("FAIL nine_busy[%0d]: got %b, want %b", k, busy_o, (k < 6));
      end
    end
    for (int i = 0; i < 2 * R; i++) begin
      if (i > 0) @(negedge clk);
      want = (cur_sel() == 1) ? 9'b0 : {2'b01, 7'b1101111};
      vectors++;
      if ({dig_en_o, seg_o} !== want) begin
        errors++;
        $display("FAIL nine_scan[%0d]: got en=%b seg=%b, want en=%b seg=%b",
                 i, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_max_value();
    logic [8:0] want;
    @(posedge clk); #1;
    drive_load(31);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 2 * R; i++) begin
      @(negedge clk);
      want = (cur_sel() == 1) ? {2'b10, 7'b1001111} : {2'b01, 7'b0000110};
      vectors++;
      if ({dig_en_o, seg_o} !== want || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL max31_scan[%0d]: got busy=%b en=%b seg=%b, want busy=0 en=%b seg=%b",
                 i, busy_o, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [8:0] want;
    @(posedge clk); #1;
    drive_load(12);
    repeat (2) @(posedge clk);
    #1;
    sum_i = 4'd7; cout_i = 1'b0; load_i = 1'b1;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3 * R; i++) begin
      @(negedge clk);
      want = (cur_sel() == 1) ? {2'b10, 7'b0000110} : {2'b01, 7'b1011011};
      vectors++;
      if ({dig_en_o, seg_o} !== want || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy[%0d]: got busy=%b en=%b seg=%b, want busy=0 en=%b seg=%b",
                 i, busy_o, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] want;
    @(posedge clk); #1;
    drive_load(20);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_o, dig_en_o, seg_o} !== {1'b0, 2'b01, 7'b0111111}) begin
      errors++;
      $display("FAIL midreset_abort: got busy=%b en=%b seg=%b, want busy=0 en=01 seg=0111111",
               busy_o, dig_en_o, seg_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_load(20);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 2 * R; i++) begin
      @(negedge clk);
      want = (cur_sel() == 1) ? {2'b10, 7'b1011011} : {2'b01, 7'b0111111};
      vectors++;
      if ({dig_en_o, seg_o} !== want || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_reload[%0d]: got busy=%b en=%b seg=%b, want busy=0 en=%b seg=%b",
                 i, busy_o, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] want;
    @(posedge clk); #1;
    drive_load(5);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      vectors++;
      if (busy_o !== (k != 6 && k != 13)) begin
        errors++;
        $display("FAIL b2b_busy[%0d]: got %b, want %b", k, busy_o, (k != 6 && k != 13));
      end
      if (k == 6) begin
        want = (cur_sel() == 1) ? 9'b0 : {2'b01, 7'b1101101};
        vectors++;
        if ({dig_en_o, seg_o} !== want) begin
          errors++;
          $display("FAIL b2b_first: got en=%b seg=%b, want en=%b seg=%b",
                   dig_en_o, seg_o, want[8:7], want[6:0]);
        end
        sum_i = 4'd0; cout_i = 1'b1; load_i = 1'b1;
      end
      if (k == 7) load_i = 1'b0;
    end
    for (int i = 0; i < 2 * R; i++) begin
      if (i > 0) @(negedge clk);
      want = (cur_sel() == 1) ? {2'b10, 7'b0000110} : {2'b01, 7'b1111101};
      vectors++;
      if ({dig_en_o, seg_o} !== want) begin
        errors++;
        $display("FAIL b2b_second[%0d]: got en=%b seg=%b, want en=%b seg=%b",
                 i, dig_en_o, seg_o, want[8:7], want[6:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] want;
    int v;
    for (int n = 0; n < 16; n++) begin
      v = int'($urandom_range(0, 31));
      @(posedge clk); #1;
      drive_load(v);
      for (int i = 0; i < 6 + 2 * R + int'($urandom_range(0, 3)); i++) begin
        @(negedge clk);
        want = exp_out();
        vectors++;
        if ({dig_en_o, seg_o} !== want || busy_o !== (busy_left > 0)) begin
          errors++;
          $display("FAIL random v=%0d c%0d: got busy=%b en=%b seg=%b, want busy=%b en=%b seg=%b",
                   v, i, busy_o, dig_en_o, seg_o, (busy_left > 0), want[8:7], want[6:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_nine();
    test_max_value();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
